rv4028_bus_responder: RTL

- Target-side counterpart of the RV4028 CPU bus. Decodes CPU memory and I/O cycles and answers them.
- Memory cycles hit an internal word RAM; the block inserts a programmable number of wait states, honours byte masks, and drives read data and its enable.
- I/O cycles reach a small countdown timer that raises int_n.
- Used as the on-chip RAM/timer target in FPGA builds and as the bus model in CPU simulation benches.

---
 rtl/rv4028_bus_pkg.sv | 35 +++
 rtl/rv4028_timer.sv | 94 +++++++++
 rtl/rv4028_bus_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rv4028_bus_pkg.sv
// Shared constants for the RV4028 bus responder: FSM encoding, timer register
// map, STATUS bit positions and byte-lane helpers.
package rv4028_bus_pkg;

  // Bus cycle FSM encoding.
  typedef logic [1:0] bus_state_t;
  localparam bus_state_t StIdle = 2'd0;
  localparam bus_state_t StWait = 2'd1;
  localparam bus_state_t StAck  = 2'd2;
  localparam bus_state_t StHold = 2'd3;

  // Timer register select (addr[1]).
  localparam logic TmrReload = 1'b0;
  localparam logic TmrStatus = 1'b1;

  // STATUS register bit positions.
  localparam int unsigned StatusPend = 0;
  localparam int unsigned StatusEn   = 1;

  // Byte lanes: msk_n bit index, lane 0 = data[7:0], lane 1 = data[15:8].
  localparam int unsigned LaneLo = 0;
  localparam int unsigned LaneHi = 1;

  // Merge a new word into an old one, replacing only lanes whose mask bit is low.
  function automatic logic [15:0] lane_merge(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic [1:0]  msk_n);
    logic [15:0] w;
    w = old_word;
    if (!msk_n[LaneLo]) w[7:0]  = new_word[7:0];
    if (!msk_n[LaneHi]) w[15:8] = new_word[15:8];
    return w;
  endfunction

endpackage

// File: rtl/rv4028_timer.sv
// Countdown timer behind the RV4028 I/O window: RELOAD/STATUS registers,
// periodic pending flag and registered active-low interrupt.
module rv4028_timer
  import rv4028_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        sel,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_msk_n,
  output logic [15:0] rd_data,
  output logic        int_n
);

  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;
  logic        int_n_q, int_n_d;

  logic wr_reload, wr_status, status_lo_we, pend_set, pend_clr;

  assign wr_reload    = wr_en && (sel == TmrReload);
  assign wr_status    = wr_en && (sel == TmrStatus);
  // PEND and EN both live in the low byte, so only lane 0 matters for STATUS.
  assign status_lo_we = wr_status && !wr_msk_n[LaneLo];

  assign pend_set = en_q && (count_q == 16'd0);
  assign pend_clr = status_lo_we && wr_data[StatusPend];

  // Next-state for reload, count, enable, pending and interrupt.
  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    en_d     = en_q;
    pend_d   = pend_q;

    if (wr_reload) begin
      reload_d = lane_merge(reload_q, wr_data, wr_msk_n);
    end

    // A RELOAD write restarts the countdown from the freshly written value.
    if (wr_reload) begin
      count_d = reload_d;
    end else if (en_q) begin
      count_d = (count_q == 16'd0) ? reload_q : count_q - 16'd1;
    end

    if (status_lo_we) begin
      en_d = wr_data[StatusEn];
    end

    // Set beats a simultaneous write-1-clear.
    if (pend_set) begin
      pend_d = 1'b1;
    end else if (pend_clr) begin
      pend_d = 1'b0;
    end

    int_n_d = ~(pend_d & en_d);
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= 16'd0;
      count_q  <= 16'd0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      int_n_q  <= 1'b1;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      int_n_q  <= int_n_d;
    end
  end

  // Register read mux.
  always_comb begin
    rd_data = 16'd0;
    if (sel == TmrStatus) begin
      rd_data[StatusPend] = pend_q;
      rd_data[StatusEn]   = en_q;
    end else begin
      rd_data = reload_q;
    end
  end

  assign int_n = int_n_q;

endmodule

// File: rtl/rv4028_bus_responder.sv
// RV4028 bus target: decodes memory and I/O cycles, inserts wait states,
// serves an internal word RAM and forwards I/O cycles to the countdown timer.
module rv4028_bus_responder
  import rv4028_bus_pkg::*;
#(
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter int unsigned WAIT_STATES    = 1,
  parameter logic [7:0]  IO_BASE        = 8'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [1:0]  msk_n,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        wait_n,
  output logic        int_n
);

  localparam int unsigned MemWords = 2 ** MEM_WORDS_LOG2;
  // Lowest address bit above the RAM window (byte address, 16-bit words).
  localparam int unsigned TagLsb   = MEM_WORDS_LOG2 + 1;
  localparam logic [2:0]  WaitLoad = 3'(WAIT_STATES);

  typedef logic [MEM_WORDS_LOG2-1:0] word_idx_t;

  // FSM and output registers.
  bus_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wait_n_q, wait_n_d;
  logic        data_oe_q, data_oe_d;
  logic [15:0] data_out_q, data_out_d;

  // Cycle attributes captured at the start edge.
  logic        is_io_q, is_rd_q, is_wr_q, sel_q;
  word_idx_t   idx_q;

  // Read data captured at the execute edge.
  logic [15:0] ram_rdata_q;
  logic [15:0] io_rdata_q;
  logic [15:0] mem [MemWords];

  // Decode.
  logic req_mem, req_io, any_strobe, mem_hit, io_hit, start, released;
  logic cyc_rd, cyc_wr;
  logic exec, x_io, x_rd, x_wr, x_sel;
  word_idx_t x_idx;
  logic mem_we, mem_re, tmr_we, tmr_re;
  logic [15:0] tmr_rdata;
  logic unused_addr0;

  assign req_mem    = !mreq_n && iorq_n;
  assign req_io     = !iorq_n && mreq_n;
  assign any_strobe = !rd_n || !wr_n;
  assign mem_hit    = (addr[31:TagLsb] == MEM_BASE[31:TagLsb]);
  assign io_hit     = (addr[7:2] == IO_BASE[7:2]);
  assign start      = (state_q == StIdle) && any_strobe &&
                      ((req_mem && mem_hit) || (req_io && io_hit));
  assign released   = (rd_n && wr_n) || (mreq_n && iorq_n);

  // Both strobes low is a protocol error: neither read nor write is performed.
  assign cyc_rd = !rd_n && wr_n;
  assign cyc_wr = !wr_n && rd_n;

  // Access executes on the start edge when there are no wait states, else on the
  // last WAIT edge; an abort on that edge wins.
  assign exec = (start && (WaitLoad == 3'd0)) ||
                ((state_q == StWait) && !released && (cnt_q == 3'd1));

  // With zero wait states the access uses live bus values, otherwise the captured ones.
  assign x_io  = (state_q == StIdle) ? req_io : is_io_q;
  assign x_rd  = (state_q == StIdle) ? cyc_rd : is_rd_q;
  assign x_wr  = (state_q == StIdle) ? cyc_wr : is_wr_q;
  assign x_sel = (state_q == StIdle) ? addr[1] : sel_q;
  assign x_idx = (state_q == StIdle) ? addr[MEM_WORDS_LOG2:1] : idx_q;

  assign mem_we = exec && !x_io && x_wr;
  assign mem_re = exec && !x_io && x_rd;
  assign tmr_we = exec && x_io && x_wr;
  assign tmr_re = exec && x_io && x_rd;

  // Byte address bit 0 has no meaning on a 16-bit word bus.
  assign unused_addr0 = addr[0];

  rv4028_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (tmr_we),
    .sel      (x_sel),
    .wr_data  (data_in),
    .wr_msk_n (msk_n),
    .rd_data  (tmr_rdata),
    .int_n    (int_n)
  );

  // Bus cycle FSM next-state and output next-state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_n_d   = wait_n_q;
    data_oe_d  = data_oe_q;
    data_out_d = data_out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          wait_n_d = 1'b0;
          cnt_d    = WaitLoad;
          state_d  = (WaitLoad == 3'd0) ? StAck : StWait;
        end
      end
      StWait: begin
        if (released) begin
          // Abort: nothing committed, CPU released immediately.
          wait_n_d = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q == 3'd1) begin
          state_d  = StAck;
        end else begin
          cnt_d    = cnt_q - 3'd1;
        end
      end
      StAck: begin
        wait_n_d = 1'b1;
        state_d  = StHold;
        if (is_rd_q) begin
          data_oe_d  = 1'b1;
          data_out_d = is_io_q ? io_rdata_q : ram_rdata_q;
        end
      end
      StHold: begin
        if (released) begin
          data_oe_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and bus output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      wait_n_q   <= 1'b1;
      data_oe_q  <= 1'b0;
      data_out_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_n_q   <= wait_n_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
    end
  end

  // Capture cycle attributes on the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_io_q <= 1'b0;
      is_rd_q <= 1'b0;
      is_wr_q <= 1'b0;
      sel_q   <= 1'b0;
      idx_q   <= '0;
    end else if (start) begin
      is_io_q <= req_io;
      is_rd_q <= cyc_rd;
      is_wr_q <= cyc_wr;
      sel_q   <= addr[1];
      idx_q   <= addr[MEM_WORDS_LOG2:1];
    end
  end

  // Timer read data captured at the execute edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata_q <= 16'd0;
    end else if (tmr_re) begin
      io_rdata_q <= tmr_rdata;
    end
  end

  // Word RAM with per-lane writes and synchronous read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !msk_n[LaneLo]) mem[x_idx][7:0]  <= data_in[7:0];
    if (mem_we && !msk_n[LaneHi]) mem[x_idx][15:8] <= data_in[15:8];
    if (mem_re) ram_rdata_q <= mem[x_idx];
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign wait_n   = wait_n_q;

endmodule
